param_combo_lock: RTL and testbench

PARAM_COMBO_LOCK -- requirements
Module: param_combo_lock

---
 rtl/param_combo_lock.sv | 208 ++++++++++++++++++++
 tb/tb_param_combo_lock.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_combo_lock.sv
// Parameterised combination lock: BCD digit entry, reprogrammable code,
// failure counting with timed lockout, and seven-segment status display.
module param_combo_lock #(
    parameter int          CODE_LEN       = 6,
    parameter logic [23:0] DEFAULT_CODE   = 24'h320474,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     digit,
    input  logic                           digit_valid,
    input  logic                           prog,
    output logic [6:0]                     HEX0,
    output logic [6:0]                     HEX1,
    output logic [6:0]                     HEX2,
    output logic [6:0]                     HEX3,
    output logic [6:0]                     HEX4,
    output logic [6:0]                     HEX5,
    output logic                           is_open,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);
    localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int TMR_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [6:0]        BLANK      = 7'b1111111;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_OPEN,
        ST_CLOSED,
        ST_PROG,
        ST_LOCKOUT
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mismatch_q, mismatch_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [3:0]          code_q [CODE_LEN];
    logic [3:0]          code_d [CODE_LEN];

    logic       digit_ok;
    logic [3:0] cur_nib;

    assign digit_ok = digit_valid && (digit <= 4'd9);
    assign cur_nib  = code_q[idx_q];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = BLANK;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ENTRY;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            fail_q     <= '0;
            tmr_q      <= '0;
            // First digit entered sits in the most significant used nibble.
            for (int i = 0; i < CODE_LEN; i++) begin
                code_q[i] <= DEFAULT_CODE[4*(CODE_LEN-1-i) +: 4];
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            fail_q     <= fail_d;
            tmr_q      <= tmr_d;
            code_q     <= code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        fail_d     = fail_q;
        tmr_d      = tmr_q;
        code_d     = code_q;
        case (state_q)
            ST_ENTRY: begin
                if (digit_ok) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        if (!mismatch_q && (digit == cur_nib)) begin
                            state_d = ST_OPEN;
                            fail_d  = '0;
                        end else begin
                            fail_d = fail_q + 1'b1;
                            if (fail_d == FAIL_LIMIT) begin
                                state_d = ST_LOCKOUT;
                                tmr_d   = '0;
                            end else begin
                                state_d = ST_CLOSED;
                            end
                        end
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        mismatch_d = mismatch_q | (digit != cur_nib);
                    end
                end
            end
            ST_CLOSED: begin
                // The waking digit is swallowed, not treated as the first code digit.
                if (digit_valid) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_OPEN: begin
                if (prog) begin
                    state_d = ST_PROG;
                    idx_d   = '0;
                end
            end
            ST_PROG: begin
                if (digit_ok) begin
                    code_d[idx_q] = digit;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ENTRY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (tmr_q == TMR_LAST) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_comb begin
        HEX0 = BLANK;
        HEX1 = BLANK;
        HEX2 = BLANK;
        HEX3 = BLANK;
        HEX4 = BLANK;
        HEX5 = BLANK;
        case (state_q)
            ST_ENTRY, ST_PROG: begin
                if (digit <= 4'd9) begin
                    HEX0 = seg7(digit);
                end else begin
                    HEX4 = 7'b0000110;
                    HEX3 = 7'b0101111;
                    HEX2 = 7'b0101111;
                    HEX1 = 7'b0100011;
                    HEX0 = 7'b0101111;
                end
                if (state_q == ST_PROG) begin
                    HEX5 = 7'b0001100;
                end
            end
            ST_OPEN: begin
                HEX3 = 7'b1000000;
                HEX2 = 7'b0001100;
                HEX1 = 7'b0000110;
                HEX0 = 7'b1001000;
            end
            ST_CLOSED: begin
                HEX5 = 7'b1000110;
                HEX4 = 7'b1000111;
                HEX3 = 7'b1000000;
                HEX2 = 7'b0010010;
                HEX1 = 7'b0000110;
                HEX0 = 7'b0100001;
            end
            ST_LOCKOUT: begin
                HEX5 = 7'b1000111;
                HEX4 = 7'b1000000;
                HEX3 = 7'b1000110;
            end
            default: ;
        endcase
    end

    assign is_open    = (state_q == ST_OPEN);
    assign locked_out = (state_q == ST_LOCKOUT);
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_param_combo_lock.sv
// Bench for param_combo_lock: sequence-level reference model checked every
// cycle, plus literal expectations for the key lock scenarios.
module tb_param_combo_lock;
    localparam int          CL  = 6;
    localparam logic [23:0] DEF = 24'h320474;
    localparam int          MF  = 3;
    localparam int          LC  = 16;

    localparam int S_ENTRY = 0, S_OPEN = 1, S_CLOSED = 2, S_PROG = 3, S_LOCK = 4;
    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, digit_valid, prog;
    logic [3:0] digit;
    logic [6:0] h0, h1, h2, h3, h4, h5;
    logic       is_open, locked_out;
    logic [1:0] fail_cnt;
    logic [6:0] g0, g1, g2, g3, g4, g5;
    logic       is_open2, locked_out2;
    logic [1:0] fail_cnt2;

    param_combo_lock #(.CODE_LEN(CL), .DEFAULT_CODE(DEF), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)) dut (
        .clk(clk), .rst_n(rst_n), .digit(digit), .digit_valid(digit_valid), .prog(prog),
        .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5),
        .is_open(is_open), .locked_out(locked_out), .fail_cnt(fail_cnt)
    );

    param_combo_lock #(.CODE_LEN(4), .DEFAULT_CODE(24'h1234), .MAX_FAILS(3), .LOCKOUT_CYCLES(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .digit(digit), .digit_valid(digit_valid), .prog(prog),
        .HEX0(g0), .HEX1(g1), .HEX2(g2), .HEX3(g3), .HEX4(g4), .HEX5(g5),
        .is_open(is_open2), .locked_out(locked_out2), .fail_cnt(fail_cnt2)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-sequence comparison on complete attempts.
    int m_state, m_fails, m_lock_left;
    int m_code[CL];
    int m_buf[$];
    bit m_ok;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = S_ENTRY; m_fails = 0; m_lock_left = 0;
            m_buf.delete();
            for (int i = 0; i < CL; i++) m_code[i] = int'((DEF >> (4*(CL-1-i))) & 24'hF);
        end else begin
            case (m_state)
                S_ENTRY: if (digit_valid && digit <= 4'd9) begin
                    m_buf.push_back(int'(digit));
                    if (m_buf.size() == CL) begin
                        m_ok = 1'b1;
                        for (int i = 0; i < CL; i++) if (m_buf[i] != m_code[i]) m_ok = 1'b0;
                        m_buf.delete();
                        if (m_ok) begin
                            m_state = S_OPEN; m_fails = 0;
                        end else begin
                            m_fails++;
                            if (m_fails == MF) begin m_state = S_LOCK; m_lock_left = LC; end
                            else m_state = S_CLOSED;
                        end
                    end
                end
                S_CLOSED: if (digit_valid) m_state = S_ENTRY;
                S_OPEN: if (prog) begin m_state = S_PROG; m_buf.delete(); end
                S_PROG: if (digit_valid && digit <= 4'd9) begin
                    m_buf.push_back(int'(digit));
                    if (m_buf.size() == CL) begin
                        for (int i = 0; i < CL; i++) m_code[i] = m_buf[i];
                        m_buf.delete();
                        m_state = S_ENTRY;
                    end
                end
                S_LOCK: begin
                    m_lock_left--;
                    if (m_lock_left == 0) begin m_state = S_ENTRY; m_fails = 0; end
                end
                default: m_state = S_ENTRY;
            endcase
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;  4'd9: return 7'b0011000;
            default: return BL;
        endcase
    endfunction

    function automatic logic [41:0] exp_disp(input int st, input logic [3:0] d);
        logic [6:0] h[6];
        for (int i = 0; i < 6; i++) h[i] = BL;
        case (st)
            S_ENTRY, S_PROG: begin
                if (d <= 4'd9) h[0] = seg_of(d);
                else begin
                    h[4] = 7'b0000110; h[3] = 7'b0101111; h[2] = 7'b0101111;
                    h[1] = 7'b0100011; h[0] = 7'b0101111;
                end
                if (st == S_PROG) h[5] = 7'b0001100;
            end
            S_OPEN: begin
                h[3] = 7'b1000000; h[2] = 7'b0001100; h[1] = 7'b0000110; h[0] = 7'b1001000;
            end
            S_CLOSED: begin
                h[5] = 7'b1000110; h[4] = 7'b1000111; h[3] = 7'b1000000;
                h[2] = 7'b0010010; h[1] = 7'b0000110; h[0] = 7'b0100001;
            end
            S_LOCK: begin
                h[5] = 7'b1000111; h[4] = 7'b1000000; h[3] = 7'b1000110;
            end
            default: ;
        endcase
        return {h[5], h[4], h[3], h[2], h[1], h[0]};
    endfunction

    logic [41:0] e;
    always @(negedge clk) begin
        if (chk_en) begin
            e = exp_disp(m_state, digit);
            chk("cyc_HEX0", h0, e[6:0]);
            chk("cyc_HEX1", h1, e[13:7]);
            chk("cyc_HEX2", h2, e[20:14]);
            chk("cyc_HEX3", h3, e[27:21]);
            chk("cyc_HEX4", h4, e[34:28]);
            chk("cyc_HEX5", h5, e[41:35]);
            chk("cyc_is_open", is_open, m_state == S_OPEN);
            chk("cyc_locked_out", locked_out, m_state == S_LOCK);
            chk("cyc_fail_cnt", fail_cnt, m_fails);
        end
    end

    task automatic drive(input logic dv, input logic [3:0] d, input logic p);
        rst_n = 1'b1; digit_valid = dv; digit = d; prog = p;
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; digit_valid = 1'b1; prog = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1; digit_valid = 1'b0; prog = 1'b0;
    endtask

    task automatic enter(input logic [23:0] code, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, code[4*(n-1-i) +: 4], 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; digit_valid = 1'b0; prog = 1'b0; digit = 4'd0;
        do_reset();
        chk_en = 1'b1;
        chk("rst_is_open", is_open, 0);
        chk("rst_locked", locked_out, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_HEX0", h0, 7'b1000000);
        chk("rst_HEX5", h5, BL);

        // Correct code opens.
        enter(24'h320474, 6);
        chk("open_is_open", is_open, 1);
        chk("open_HEX", {h3, h2, h1, h0}, {7'b1000000, 7'b0001100, 7'b0000110, 7'b1001000});
        chk("open_fail_cnt", fail_cnt, 0);

        // Wrong last digit closes; a strobe returns to entry.
        do_reset();
        enter(24'h320475, 6);
        chk("closed_HEX", {h5, h4, h3, h2, h1, h0},
            {7'b1000110, 7'b1000111, 7'b1000000, 7'b0010010, 7'b0000110, 7'b0100001});
        chk("closed_fail_cnt", fail_cnt, 1);
        drive(1'b1, 4'd8, 1'b0);
        chk("reentry_HEX0", h0, 7'b0000000);
        chk("reentry_HEX5", h5, BL);
        chk("reentry_fail_cnt", fail_cnt, 1);

        // Three wrong attempts lock out for exactly LC cycles.
        do_reset();
        enter(24'h111111, 6); drive(1'b1, 4'd0, 1'b0);
        enter(24'h320470, 6); drive(1'b1, 4'd0, 1'b0);
        enter(24'h020474, 6);
        chk("lock_locked", locked_out, 1);
        chk("lock_fail_cnt", fail_cnt, 3);
        chk("lock_HEX", {h5, h4, h3, h2}, {7'b1000111, 7'b1000000, 7'b1000110, BL});
        for (int i = 0; i < LC - 1; i++) drive(1'b1, DEF[4*(5-(i%6)) +: 4], 1'b1);
        chk("lock_still", locked_out, 1);
        drive(1'b0, 4'd0, 1'b0);
        chk("lock_exit", locked_out, 0);
        chk("lock_exit_fail_cnt", fail_cnt, 0);
        chk("lock_exit_HEX0", h0, 7'b1000000);

        // Reprogramming.
        enter(24'h320474, 6);
        drive(1'b1, 4'd5, 1'b0);
        chk("open_ignores_digit", is_open, 1);
        drive(1'b1, 4'd5, 1'b1);
        chk("prog_HEX5", h5, 7'b0001100);
        chk("prog_HEX0", h0, 7'b0010010);
        drive(1'b1, 4'hC, 1'b0);
        enter(24'h112233, 6);
        chk("prog_done_open", is_open, 0);
        chk("prog_done_HEX5", h5, BL);
        enter(24'h320474, 6);
        chk("old_code_closed", h0, 7'b0100001);
        drive(1'b1, 4'd9, 1'b0);
        enter(24'h112233, 6);
        chk("new_code_open", is_open, 1);
        do_reset();
        enter(24'h320474, 6);
        chk("reset_restores_code", is_open, 1);

        // Out-of-range digit shows ErrOr and is ignored.
        do_reset();
        drive(1'b1, 4'd3, 1'b0);
        drive(1'b1, 4'd12, 1'b0);
        chk("err_HEX", {h4, h3, h2, h1, h0},
            {7'b0000110, 7'b0101111, 7'b0101111, 7'b0100011, 7'b0101111});
        enter(24'h020474, 5);
        chk("err_then_open", is_open, 1);

        // Mid-entry reset clears the index.
        do_reset();
        drive(1'b1, 4'd3, 1'b0);
        drive(1'b1, 4'd7, 1'b0);
        do_reset();
        enter(24'h320474, 6);
        chk("midreset_open", is_open, 1);

        // Four-digit build.
        do_reset();
        enter(24'h000123, 3);
        chk("len4_not_yet", is_open2, 0);
        drive(1'b1, 4'd4, 1'b0);
        chk("len4_open", is_open2, 1);
        chk("len4_HEX0", g0, 7'b1001000);
        chk("len4_fail_cnt", fail_cnt2, 0);
        chk("main_not_open", is_open, 0);

        drive(1'b0, 4'd0, 1'b0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
